cpu_nic: RTL and testbench
==========================

Name: cpu_nic

Overview:
- Network interface between the 3-stage pipeline's NIC port (nicEn/nicEnWr/adder_nic, nic_dataIn, nic_dataOut) and one router port.
- Holds one 64-bit output-channel buffer (processor→router) and one 64-bit input-channel buffer (router→processor), each with a full flag.
- The processor polls the flags through memory-mapped status registers and moves data with NIC load/store instructions.
- Sits directly downstream of pipeline stage 2 (decode drives the request) and feeds the stage-3 result mux (nic_dataOut).

Parameters:
DATA_WIDTH, 64, width of data words and channel buffers
ADDR_WIDTH, 2, width of processor-side register address

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-low reset
nicEn  input  1  processor access request this cycle
nicEnWr  input  1  1 = write, 0 = read (valid only with nicEn)
adder_nic  input  ADDR_WIDTH  register select
nic_dataIn  input  DATA_WIDTH  processor write data
nic_dataOut  output  DATA_WIDTH  registered read data to pipeline stage 3
net_so  output  1  send valid to router (output buffer full)
net_ro  input  1  router ready to accept
net_do  output  DATA_WIDTH  data to router (output buffer contents)
net_si  input  1  router send valid
net_ri  output  1  ready to router (input buffer empty)
net_di  input  DATA_WIDTH  data from router

Behaviour:
- Reset (rst=0, async): both buffers cleared to 0, both full flags 0, nic_dataOut=0. Resulting outputs: net_so=0, net_do=0, net_ri=1.
- Address map:
  - 2'b00: input buffer (read)
  - 2'b01: input status (read)
  - 2'b10: output buffer (write)
  - 2'b11: output status (read)
- Read latency 1 cycle. When nicEn=1 and nicEnWr=0 at edge N, nic_dataOut updates at edge N and holds until the next read.
  - Without a read, nic_dataOut holds its value.
  - Status reads return {63'b0, flag}.
  - A read of 2'b10 returns 0.
- Read of 2'b00 with in_full=1: nic_dataOut<=in_buf and in_full clears at the same edge.
- Read of 2'b00 with in_full=0: returns current in_buf contents (stale) and changes no state.
- Write (nicEn=1, nicEnWr=1) to 2'b10 with out_full=0: out_buf<=nic_dataIn and out_full<=1.
  - Write to 2'b10 with out_full=1: dropped, buffer unchanged. This holds even if the router drains the buffer on the same edge; software must poll 2'b11 first.
  - Writes to any other address are ignored.
- Output channel:
  - net_so=out_full and net_do=out_buf, both combinational from registers.
  - Handshake completes when net_so=1 and net_ro=1 at an edge; out_full then clears.
  - net_do stays stable while net_so=1.
- Input channel:
  - net_ri=~in_full.
  - When net_si=1 and net_ri=1 at an edge: in_buf<=net_di and in_full<=1.
  - When net_si=1 and net_ri=0: nothing is captured; the router must hold its data.
- Simultaneous events:
  - A processor read clearing in_full cannot coincide with a capture, because net_ri=0 in that cycle; capture happens at the following edge at the earliest.
  - Processor and router sides otherwise operate independently in the same cycle.
- nicEnWr and adder_nic are don't-care when nicEn=0.
- Reset asserted mid-transfer aborts it: flags clear immediately and buffered data is lost.

Decomposition:
- Shared package holds:
  - address constants NIC_IN_BUF=2'b00, NIC_IN_STAT=2'b01, NIC_OUT_BUF=2'b10, NIC_OUT_STAT=2'b11
  - DATA_WIDTH default
- One natural sub-module: nic_channel_buf, a one-entry buffer with a full flag.
  - Ports: load, load_data, unload, full, data.
  - Instantiated twice: input side (load=router capture, unload=processor read) and output side (load=processor write, unload=router handshake).

Test Plan:
- Reset: with traffic toggling, pull rst low mid-cycle -> immediately net_so=0, net_ri=1, nic_dataOut=0.
- Write 64'hDEAD_BEEF_0000_0001 to 2'b10 with net_ro=0 -> net_so=1 and net_do=that value. A second write of 64'h2 is dropped. Raise net_ro for one cycle -> net_so=0; a status read of 2'b11 then returns 0.
- Router drives net_si=1 with net_di=64'h0123_4567_89AB_CDEF -> net_ri=0 next cycle and a read of 2'b01 returns 1. A read of 2'b00 returns the data one cycle later and net_ri=1 again.
- With in_full=1, router presents 64'h5 with net_si=1 for 3 cycles -> not captured until the processor reads 2'b00, then captured on the following edge; the next read returns 64'h5.
- Write to 2'b10 on the same edge that the router drains a full buffer -> write dropped, out_full=0 afterwards. Read of 2'b00 while empty -> stale data returned, flags unchanged.
- Back-to-back traffic: the processor sends 4 words, each after a poll returns 0, while the router accepts every other cycle -> the router receives all 4 in order with no loss or duplication.

Source files
------------

// File: rtl/cpu_nic_pkg.sv
// Shared constants for the CPU network interface: widths and the processor-side register map.
package cpu_nic_pkg;

  localparam int unsigned NIC_DATA_WIDTH = 64;
  localparam int unsigned NIC_ADDR_WIDTH = 2;

  localparam logic [NIC_ADDR_WIDTH-1:0] NIC_IN_BUF   = 2'b00;
  localparam logic [NIC_ADDR_WIDTH-1:0] NIC_IN_STAT  = 2'b01;
  localparam logic [NIC_ADDR_WIDTH-1:0] NIC_OUT_BUF  = 2'b10;
  localparam logic [NIC_ADDR_WIDTH-1:0] NIC_OUT_STAT = 2'b11;

endpackage

// File: rtl/cpu_nic_if.sv
// Pipeline NIC port plus one router port, bundled; slave is the NIC side.
interface cpu_nic_if
  import cpu_nic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = NIC_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = NIC_ADDR_WIDTH
);

  logic                  nicEn;
  logic                  nicEnWr;
  logic [ADDR_WIDTH-1:0] adder_nic;
  logic [DATA_WIDTH-1:0] nic_dataIn;
  logic [DATA_WIDTH-1:0] nic_dataOut;

  logic                  net_so;
  logic                  net_ro;
  logic [DATA_WIDTH-1:0] net_do;
  logic                  net_si;
  logic                  net_ri;
  logic [DATA_WIDTH-1:0] net_di;

  modport slave (
    input  nicEn, nicEnWr, adder_nic, nic_dataIn, net_ro, net_si, net_di,
    output nic_dataOut, net_so, net_do, net_ri
  );

  modport master (
    output nicEn, nicEnWr, adder_nic, nic_dataIn, net_ro, net_si, net_di,
    input  nic_dataOut, net_so, net_do, net_ri
  );

endinterface

// File: rtl/nic_channel_buf.sv
// One-entry channel buffer with a full flag; loads only when empty, unload only clears the flag.
module nic_channel_buf #(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         unload,
  output logic         full,
  output logic [W-1:0] data
);

  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;

  // A full buffer ignores load even when it drains on the same edge.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (full_q) begin
      full_d = ~unload;
    end else if (load) begin
      full_d = 1'b1;
      data_d = load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full = full_q;
  assign data = data_q;

endmodule

// File: rtl/cpu_nic.sv
// Network interface between the pipeline NIC port and a router port: one buffer per direction,
// memory-mapped status flags, one-cycle registered read data.
module cpu_nic
  import cpu_nic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = NIC_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = NIC_ADDR_WIDTH
) (
  input  logic     clk,
  input  logic     rst,
  cpu_nic_if.slave bus
);

  logic                  rd_en;
  logic                  in_unload;
  logic                  out_load;
  logic                  in_full;
  logic                  out_full;
  logic [DATA_WIDTH-1:0] in_data;
  logic [DATA_WIDTH-1:0] out_data;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;

  assign rd_en     = bus.nicEn & ~bus.nicEnWr;
  assign in_unload = rd_en & (bus.adder_nic == ADDR_WIDTH'(NIC_IN_BUF));
  assign out_load  = bus.nicEn & bus.nicEnWr & (bus.adder_nic == ADDR_WIDTH'(NIC_OUT_BUF));

  // Router to processor: router capture loads, processor read of the buffer unloads.
  nic_channel_buf #(.W(DATA_WIDTH)) u_in_buf (
    .clk       (clk),
    .rst_n     (rst),
    .load      (bus.net_si),
    .load_data (bus.net_di),
    .unload    (in_unload),
    .full      (in_full),
    .data      (in_data)
  );

  // Processor to router: processor write loads, router handshake unloads.
  nic_channel_buf #(.W(DATA_WIDTH)) u_out_buf (
    .clk       (clk),
    .rst_n     (rst),
    .load      (out_load),
    .load_data (bus.nic_dataIn),
    .unload    (bus.net_ro),
    .full      (out_full),
    .data      (out_data)
  );

  // Read mux; the last read value holds until the next read.
  always_comb begin
    dout_d = dout_q;
    if (rd_en) begin
      case (bus.adder_nic)
        ADDR_WIDTH'(NIC_IN_BUF):   dout_d = in_data;
        ADDR_WIDTH'(NIC_IN_STAT):  dout_d = DATA_WIDTH'(in_full);
        ADDR_WIDTH'(NIC_OUT_STAT): dout_d = DATA_WIDTH'(out_full);
        default:                   dout_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign bus.nic_dataOut = dout_q;
  assign bus.net_so      = out_full;
  assign bus.net_do      = out_data;
  assign bus.net_ri      = ~in_full;

endmodule

// File: tb/tb_cpu_nic.sv
// Directed self-checking bench for cpu_nic.
module tb_cpu_nic;
  import cpu_nic_pkg::*;

  typedef logic [63:0] word_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cpu_nic_if #(.DATA_WIDTH(64), .ADDR_WIDTH(2)) bus ();

  cpu_nic #(.DATA_WIDTH(64), .ADDR_WIDTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  word_t rx[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [1:0] a, input word_t d);
    bus.nicEn = 1'b1; bus.nicEnWr = 1'b1; bus.adder_nic = a; bus.nic_dataIn = d;
    tick();
    bus.nicEn = 1'b0; bus.nicEnWr = 1'b0;
  endtask

  task automatic cpu_read(input logic [1:0] a);
    bus.nicEn = 1'b1; bus.nicEnWr = 1'b0; bus.adder_nic = a;
    tick();
    bus.nicEn = 1'b0;
  endtask

  task automatic test_reset();
    bus.nicEn = 1'b0; bus.nicEnWr = 1'b0; bus.adder_nic = 2'b00; bus.nic_dataIn = '0;
    bus.net_ro = 1'b0; bus.net_si = 1'b0; bus.net_di = '0;
    rst = 1'b0;
    #12;
    total++; if (bus.net_so !== 1'b0) begin bad++; $display("FAIL rst_so got=%0h want=0", bus.net_so); end
    total++; if (bus.net_ri !== 1'b1) begin bad++; $display("FAIL rst_ri got=%0h want=1", bus.net_ri); end
    total++; if (bus.nic_dataOut !== 64'h0) begin bad++; $display("FAIL rst_dout got=%h want=0", bus.nic_dataOut); end
    total++; if (bus.net_do !== 64'h0) begin bad++; $display("FAIL rst_do got=%h want=0", bus.net_do); end
    rst = 1'b1;
    tick();
    cpu_write(NIC_OUT_BUF, 64'hCAFE_0000_0000_0001);
    bus.net_si = 1'b1; bus.net_di = 64'h1111;
    tick();
    bus.net_si = 1'b0;
    cpu_read(NIC_OUT_STAT);
    total++; if (bus.net_so !== 1'b1) begin bad++; $display("FAIL pre_rst_so got=%0h want=1", bus.net_so); end
    total++; if (bus.net_ri !== 1'b0) begin bad++; $display("FAIL pre_rst_ri got=%0h want=0", bus.net_ri); end
    total++; if (bus.nic_dataOut !== 64'h1) begin bad++; $display("FAIL pre_rst_dout got=%h want=1", bus.nic_dataOut); end
    bus.net_si = 1'b1; bus.net_di = 64'h2222;
    #3 rst = 1'b0;
    #1;
    total++; if (bus.net_so !== 1'b0) begin bad++; $display("FAIL mid_rst_so got=%0h want=0", bus.net_so); end
    total++; if (bus.net_ri !== 1'b1) begin bad++; $display("FAIL mid_rst_ri got=%0h want=1", bus.net_ri); end
    total++; if (bus.nic_dataOut !== 64'h0) begin bad++; $display("FAIL mid_rst_dout got=%h want=0", bus.nic_dataOut); end
    total++; if (bus.net_do !== 64'h0) begin bad++; $display("FAIL mid_rst_do got=%h want=0", bus.net_do); end
    bus.net_si = 1'b0;
    #2 rst = 1'b1;
    tick();
  endtask

  task automatic test_write_out();
    bus.net_ro = 1'b0;
    cpu_write(NIC_OUT_BUF, 64'hDEAD_BEEF_0000_0001);
    total++; if (bus.net_so !== 1'b1) begin bad++; $display("FAIL wr_so got=%0h want=1", bus.net_so); end
    total++; if (bus.net_do !== 64'hDEAD_BEEF_0000_0001) begin bad++; $display("FAIL wr_do got=%h want=deadbeef00000001", bus.net_do); end
    cpu_read(NIC_OUT_STAT);
    total++; if (bus.nic_dataOut !== 64'h1) begin bad++; $display("FAIL wr_stat_full got=%h want=1", bus.nic_dataOut); end
    cpu_write(NIC_OUT_BUF, 64'h2);
    total++; if (bus.net_do !== 64'hDEAD_BEEF_0000_0001) begin bad++; $display("FAIL wr_drop_do got=%h want=deadbeef00000001", bus.net_do); end
    bus.net_ro = 1'b1;
    tick();
    bus.net_ro = 1'b0;
    total++; if (bus.net_so !== 1'b0) begin bad++; $display("FAIL drain_so got=%0h want=0", bus.net_so); end
    cpu_read(NIC_OUT_STAT);
    total++; if (bus.nic_dataOut !== 64'h0) begin bad++; $display("FAIL drain_stat got=%h want=0", bus.nic_dataOut); end
  endtask

  task automatic test_read_in();
    bus.net_si = 1'b1; bus.net_di = 64'h0123_4567_89AB_CDEF;
    tick();
    bus.net_si = 1'b0;
    total++; if (bus.net_ri !== 1'b0) begin bad++; $display("FAIL in_ri_full got=%0h want=0", bus.net_ri); end
    cpu_read(NIC_IN_STAT);
    total++; if (bus.nic_dataOut !== 64'h1) begin bad++; $display("FAIL in_stat got=%h want=1", bus.nic_dataOut); end
    cpu_read(NIC_IN_BUF);
    total++; if (bus.nic_dataOut !== 64'h0123_4567_89AB_CDEF) begin bad++; $display("FAIL in_data got=%h want=0123456789abcdef", bus.nic_dataOut); end
    total++; if (bus.net_ri !== 1'b1) begin bad++; $display("FAIL in_ri_empty got=%0h want=1", bus.net_ri); end
  endtask

  task automatic test_backpressure();
    bus.net_si = 1'b1; bus.net_di = 64'h77;
    tick();
    bus.net_di = 64'h5;
    repeat (3) tick();
    total++; if (bus.net_ri !== 1'b0) begin bad++; $display("FAIL bp_ri got=%0h want=0", bus.net_ri); end
    cpu_read(NIC_IN_BUF);
    total++; if (bus.nic_dataOut !== 64'h77) begin bad++; $display("FAIL bp_first got=%h want=77", bus.nic_dataOut); end
    total++; if (bus.net_ri !== 1'b1) begin bad++; $display("FAIL bp_ri_free got=%0h want=1", bus.net_ri); end
    tick();
    bus.net_si = 1'b0;
    total++; if (bus.net_ri !== 1'b0) begin bad++; $display("FAIL bp_capture_ri got=%0h want=0", bus.net_ri); end
    cpu_read(NIC_IN_BUF);
    total++; if (bus.nic_dataOut !== 64'h5) begin bad++; $display("FAIL bp_second got=%h want=5", bus.nic_dataOut); end
  endtask

  task automatic test_drop_on_drain();
    bus.net_ro = 1'b0;
    cpu_write(NIC_OUT_BUF, 64'hAAA);
    bus.net_ro = 1'b1;
    cpu_write(NIC_OUT_BUF, 64'hBBB);
    bus.net_ro = 1'b0;
    total++; if (bus.net_so !== 1'b0) begin bad++; $display("FAIL dd_so got=%0h want=0", bus.net_so); end
    total++; if (bus.net_do !== 64'hAAA) begin bad++; $display("FAIL dd_do got=%h want=aaa", bus.net_do); end
    cpu_read(NIC_OUT_STAT);
    total++; if (bus.nic_dataOut !== 64'h0) begin bad++; $display("FAIL dd_stat got=%h want=0", bus.nic_dataOut); end
    cpu_read(NIC_IN_BUF);
    total++; if (bus.nic_dataOut !== 64'h5) begin bad++; $display("FAIL stale_data got=%h want=5", bus.nic_dataOut); end
    total++; if (bus.net_ri !== 1'b1) begin bad++; $display("FAIL stale_ri got=%0h want=1", bus.net_ri); end
    cpu_read(NIC_OUT_BUF);
    total++; if (bus.nic_dataOut !== 64'h0) begin bad++; $display("FAIL rd_outbuf got=%h want=0", bus.nic_dataOut); end
    cpu_read(NIC_IN_STAT);
    total++; if (bus.nic_dataOut !== 64'h0) begin bad++; $display("FAIL stale_stat got=%h want=0", bus.nic_dataOut); end
  endtask

  task automatic test_back_to_back();
    word_t words[4];
    words[0] = 64'h1000_0000_0000_000A;
    words[1] = 64'h2000_0000_0000_000B;
    words[2] = 64'h3000_0000_0000_000C;
    words[3] = 64'h4000_0000_0000_000D;
    rx.delete();
    fork
      begin
        for (int c = 0; c < 60; c++) begin
          bus.net_ro = c[0];
          @(negedge clk);
          if (bus.net_so && bus.net_ro) rx.push_back(bus.net_do);
          @(posedge clk);
          #1;
        end
        bus.net_ro = 1'b0;
      end
      begin
        for (int i = 0; i < 4; i++) begin
          int tries;
          tries = 0;
          do begin
            cpu_read(NIC_OUT_STAT);
            tries++;
          end while (bus.nic_dataOut !== 64'h0 && tries < 20);
          total++; if (bus.nic_dataOut !== 64'h0) begin bad++; $display("FAIL b2b_poll%0d got=%h want=0", i, bus.nic_dataOut); end
          cpu_write(NIC_OUT_BUF, words[i]);
        end
      end
    join
    total++; if (rx.size() != 4) begin bad++; $display("FAIL b2b_count got=%0d want=4", rx.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < rx.size()) begin
        total++; if (rx[i] !== words[i]) begin bad++; $display("FAIL b2b_word%0d got=%h want=%h", i, rx[i], words[i]); end
      end
    end
    total++; if (bus.net_so !== 1'b0) begin bad++; $display("FAIL b2b_idle_so got=%0h want=0", bus.net_so); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_out();
    test_read_in();
    test_backpressure();
    test_drop_on_drain();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
